// File: rtl/board_writer_pkg.sv
// Shared definitions for the tic-tac-toe board writer and its helpers.
package board_writer_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;

  typedef enum logic {
    ST_PLAY   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam logic [3:0] MAX_MOVES = 4'd9;
  localparam logic [3:0] SEL_MIN   = 4'd1;
  localparam logic [3:0] SEL_MAX   = 4'd9;

  // Cell code of the opponent of player p.
  function automatic logic [1:0] other_player(input logic [1:0] p);
    return (p == CELL_P1) ? CELL_P2 : CELL_P1;
  endfunction

endpackage

// File: rtl/board_writer_rise_detect.sv
// Registered rising-edge detector with a synchronous history load.
module rise_detect (
  input  logic clk,
  input  logic load,
  input  logic load_val,
  input  logic din,
  output logic rise
);

  logic hist;

  // History flop: forced to load_val on load, otherwise tracks din.
  always_ff @(posedge clk) begin
    if (load) hist <= load_val;
    else      hist <= din;
  end

  assign rise = din & ~hist;

endmodule

// File: rtl/board_writer.sv
// Sole writer of the 3x3 board: validates move requests, commits legal
// moves, alternates turns and locks the board when the game ends.
module board_writer
  import board_writer_pkg::*;
#(
  parameter logic [1:0] FIRST_PLAYER = CELL_P1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       move_req,
  input  logic [3:0] move_sel,
  input  logic       game_over,
  output logic [1:0] pos1,
  output logic [1:0] pos2,
  output logic [1:0] pos3,
  output logic [1:0] pos4,
  output logic [1:0] pos5,
  output logic [1:0] pos6,
  output logic [1:0] pos7,
  output logic [1:0] pos8,
  output logic [1:0] pos9,
  output logic [1:0] turn,
  output logic [3:0] move_count,
  output logic       move_accept,
  output logic       move_reject,
  output logic       locked
);

  logic [1:0] cells [9];
  state_t     state, state_next;
  logic       req_edge;
  logic       sel_valid;
  logic [1:0] sel_cell;
  logic       accept;

  // Reset arms the history high so a held button does not fire; clear
  // loads the live level so a press held across clear does not fire.
  rise_detect u_req_edge (
    .clk      (clk),
    .load     (reset | clear),
    .load_val (reset | move_req),
    .din      (move_req),
    .rise     (req_edge)
  );

  // Select the target cell and decide whether this request is legal.
  always_comb begin
    sel_valid = (move_sel >= SEL_MIN) && (move_sel <= SEL_MAX);
    sel_cell  = CELL_EMPTY;
    for (int unsigned i = 0; i < 9; i++) begin
      if (move_sel == 4'(i + 1)) sel_cell = cells[i];
    end
    accept = req_edge && (state == ST_PLAY) && !game_over &&
             sel_valid && (sel_cell == CELL_EMPTY);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset || clear) state <= ST_PLAY;
    else                state <= state_next;
  end

  // Next-state logic: lock on a win or on the move that fills the board.
  always_comb begin
    state_next = state;
    case (state)
      ST_PLAY: begin
        if (game_over)                                   state_next = ST_LOCKED;
        else if (accept && move_count == MAX_MOVES - 4'd1) state_next = ST_LOCKED;
      end
      ST_LOCKED: state_next = ST_LOCKED;
      default:   state_next = ST_PLAY;
    endcase
  end

  // Output decode of the state register.
  always_comb begin
    locked = (state == ST_LOCKED);
  end

  // Board, turn, move counter and result pulses.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int unsigned i = 0; i < 9; i++) cells[i] <= CELL_EMPTY;
      turn        <= FIRST_PLAYER;
      move_count  <= '0;
      move_accept <= 1'b0;
      move_reject <= 1'b0;
    end else begin
      move_accept <= accept;
      move_reject <= req_edge && !accept;
      if (accept) begin
        for (int unsigned i = 0; i < 9; i++) begin
          if (move_sel == 4'(i + 1)) cells[i] <= turn;
        end
        turn       <= other_player(turn);
        move_count <= move_count + 4'd1;
      end
    end
  end

  assign pos1 = cells[0];
  assign pos2 = cells[1];
  assign pos3 = cells[2];
  assign pos4 = cells[3];
  assign pos5 = cells[4];
  assign pos6 = cells[5];
  assign pos7 = cells[6];
  assign pos8 = cells[7];
  assign pos9 = cells[8];

endmodule

// File: tb/tb_board_writer.sv
// Directed self-checking bench for board_writer.
module tb_board_writer;

  logic       clk = 1'b0;
  logic       reset, clear, move_req, game_over;
  logic [3:0] move_sel;
  logic [1:0] pos [9];
  logic [1:0] turn;
  logic [3:0] move_count;
  logic       move_accept, move_reject, locked;

  int checks = 0;
  int errors = 0;

  board_writer #(.FIRST_PLAYER(2'b01)) dut (
    .clk(clk), .reset(reset), .clear(clear), .move_req(move_req),
    .move_sel(move_sel), .game_over(game_over),
    .pos1(pos[0]), .pos2(pos[1]), .pos3(pos[2]), .pos4(pos[3]), .pos5(pos[4]),
    .pos6(pos[5]), .pos7(pos[6]), .pos8(pos[7]), .pos9(pos[8]),
    .turn(turn), .move_count(move_count), .move_accept(move_accept),
    .move_reject(move_reject), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request edge; checks the pulse the cycle after and its release.
  task automatic press(input logic [3:0] sel, input logic exp_acc, input string tag);
    move_sel = sel;
    move_req = 1'b1;
    chk({tag, "_pre_acc"}, 32'(move_accept), 32'd0);
    tick();
    chk({tag, "_acc"}, 32'(move_accept), 32'(exp_acc));
    chk({tag, "_rej"}, 32'(move_reject), 32'(!exp_acc));
    move_req = 1'b0;
    tick();
    chk({tag, "_acc_end"}, 32'(move_accept), 32'd0);
    chk({tag, "_rej_end"}, 32'(move_reject), 32'd0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic chk_empty(input string tag);
    for (int i = 0; i < 9; i++) chk($sformatf("%s_pos%0d", tag, i + 1), 32'(pos[i]), 32'd0);
    chk({tag, "_turn"}, 32'(turn), 32'd1);
    chk({tag, "_count"}, 32'(move_count), 32'd0);
    chk({tag, "_locked"}, 32'(locked), 32'd0);
    chk({tag, "_acc"}, 32'(move_accept), 32'd0);
    chk({tag, "_rej"}, 32'(move_reject), 32'd0);
  endtask

  initial begin
    int acc_cnt, rej_cnt, n1, n2;
    logic [3:0] seq [9];
    seq = '{4'd5, 4'd1, 4'd9, 4'd3, 4'd2, 4'd8, 4'd4, 4'd6, 4'd7};

    reset = 1'b1; clear = 1'b0; move_req = 1'b1; game_over = 1'b0; move_sel = 4'd5;
    tick(); tick();
    reset = 1'b0;
    tick();
    // Button held through reset must not fire.
    chk_empty("reset");
    move_req = 1'b0;
    tick();

    // Three legal moves.
    press(4'd5, 1'b1, "m5");
    press(4'd1, 1'b1, "m1");
    press(4'd9, 1'b1, "m9");
    chk("seq_pos5", 32'(pos[4]), 32'd1);
    chk("seq_pos1", 32'(pos[0]), 32'd2);
    chk("seq_pos9", 32'(pos[8]), 32'd1);
    chk("seq_count", 32'(move_count), 32'd3);
    chk("seq_turn", 32'(turn), 32'd2);

    // Occupied cell.
    press(4'd5, 1'b0, "occ5");
    chk("occ_pos5", 32'(pos[4]), 32'd1);
    chk("occ_turn", 32'(turn), 32'd2);
    chk("occ_count", 32'(move_count), 32'd3);

    // Long hold gives one accept only.
    do_clear();
    chk_empty("clr1");
    move_sel = 4'd3;
    move_req = 1'b1;
    acc_cnt = 0; rej_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (move_accept) acc_cnt++;
      if (move_reject) rej_cnt++;
    end
    move_req = 1'b0;
    tick();
    chk("hold_acc_cnt", 32'(acc_cnt), 32'd1);
    chk("hold_rej_cnt", 32'(rej_cnt), 32'd0);
    chk("hold_pos3", 32'(pos[2]), 32'd1);
    chk("hold_count", 32'(move_count), 32'd1);

    // Fill the board.
    do_clear();
    for (int k = 0; k < 9; k++) begin
      press(seq[k], 1'b1, $sformatf("fill%0d", k));
      chk($sformatf("fill%0d_locked", k), 32'(locked), 32'(k == 8));
    end
    chk("full_count", 32'(move_count), 32'd9);
    n1 = 0; n2 = 0;
    for (int i = 0; i < 9; i++) begin
      if (pos[i] == 2'b01) n1++;
      if (pos[i] == 2'b10) n2++;
    end
    chk("full_p1", 32'(n1), 32'd5);
    chk("full_p2", 32'(n2), 32'd4);
    chk("full_pos7", 32'(pos[6]), 32'd1);
    chk("full_pos6", 32'(pos[5]), 32'd2);
    press(4'd5, 1'b0, "tenth");
    chk("tenth_count", 32'(move_count), 32'd9);

    // game_over with a move edge.
    do_clear();
    game_over = 1'b1;
    press(4'd2, 1'b0, "go2");
    chk("go_pos2", 32'(pos[1]), 32'd0);
    chk("go_locked", 32'(locked), 32'd1);
    chk("go_count", 32'(move_count), 32'd0);
    game_over = 1'b0;
    press(4'd2, 1'b0, "lockedmove");
    chk("lk_pos2", 32'(pos[1]), 32'd0);
    do_clear();
    chk_empty("clr2");

    // Out-of-range selectors.
    press(4'd0, 1'b0, "sel0");
    press(4'd12, 1'b0, "sel12");
    chk("bad_count", 32'(move_count), 32'd0);
    chk("bad_turn", 32'(turn), 32'd1);

    // clear collides with a move edge.
    clear = 1'b1;
    move_sel = 4'd4;
    move_req = 1'b1;
    tick();
    clear = 1'b0;
    chk("clrmv_acc", 32'(move_accept), 32'd0);
    chk("clrmv_rej", 32'(move_reject), 32'd0);
    tick();
    chk("clrmv_acc2", 32'(move_accept), 32'd0);
    chk("clrmv_rej2", 32'(move_reject), 32'd0);
    chk("clrmv_pos4", 32'(pos[3]), 32'd0);
    chk("clrmv_count", 32'(move_count), 32'd0);
    move_req = 1'b0;
    tick();
    press(4'd4, 1'b1, "after_clr");
    chk("after_pos4", 32'(pos[3]), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
